moore_1010_non_overlap: RTL and testbench



---
 rtl/moore_1010_non_overlap_pkg.sv | 19 +
 rtl/moore_1010_non_overlap.sv | 37 +++
 tb/tb_moore_1010_non_overlap.sv | 90 +++++++++
 3 files changed

// File: rtl/moore_1010_non_overlap_pkg.sv
// rtl/moore_1010_non_overlap_pkg.sv - state encoding shared by the 1010 detector and its users
package moore_1010_non_overlap_pkg;

  // S1..S4 name the prefix of 1,0,1,0 matched so far; S4 is the full match.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam state_t DETECT_STATE = S4;

  function automatic logic is_detect(input state_t st);
    return (st == DETECT_STATE);
  endfunction

endpackage

// File: rtl/moore_1010_non_overlap.sv
// rtl/moore_1010_non_overlap.sv - non-overlapping Moore detector for serial pattern 1,0,1,0
module moore_1010_non_overlap
  import moore_1010_non_overlap_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic c,
  output logic d
);

  state_t r_state;
  state_t w_next_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S0;
    case (r_state)
      S0: w_next_state = c ? S1 : S0;
      S1: w_next_state = c ? S1 : S2;
      S2: w_next_state = c ? S3 : S0;
      S3: w_next_state = c ? S1 : S4;
      // A completed match is consumed whole: restart as if from idle.
      S4: w_next_state = c ? S1 : S0;
      default: w_next_state = S0;
    endcase
  end

  assign d = is_detect(r_state);

endmodule

// File: tb/tb_moore_1010_non_overlap.sv
// tb/tb_moore_1010_non_overlap.sv - directed self-checking bench for the 1010 detector
module tb_moore_1010_non_overlap;

  logic clk;
  logic reset;
  logic c;
  logic d;

  int n_tests;
  int n_fail;

  moore_1010_non_overlap dut (
    .clk  (clk),
    .reset(reset),
    .c    (c),
    .d    (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: d=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input string tag, input int n_edges);
    for (int i = 0; i < n_edges; i++) begin
      @(negedge clk);
      reset = 1'b0;
      c = i[0];
      @(posedge clk);
      #1;
      check_eq($sformatf("%s_rst%0d", tag, i), d, 1'b0);
    end
  endtask

  // bits/exp are listed first-bit-first from position n-1 down to 0.
  task automatic run_seq(input string tag, input logic [31:0] bits,
                         input logic [31:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      reset = 1'b1;
      c = bits[i];
      @(posedge clk);
      #1;
      check_eq($sformatf("%s_b%0d", tag, n - i), d, exp[i]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    c       = 1'b0;

    apply_reset("init", 2);
    run_seq("basic", 32'b1010, 32'b0001, 4);

    apply_reset("nonovl", 1);
    run_seq("nonovl", 32'b101010, 32'b000100, 6);

    apply_reset("b2b", 1);
    run_seq("b2b", 32'b10101010, 32'b00010001, 8);

    apply_reset("pfx1", 1);
    run_seq("pfx1", 32'b111010, 32'b000001, 6);

    apply_reset("pfx2", 1);
    run_seq("pfx2", 32'b1001010, 32'b0000001, 7);

    apply_reset("mid", 1);
    run_seq("mid_a", 32'b101, 32'b000, 3);
    apply_reset("mid", 1);
    run_seq("mid_b", 32'b0, 32'b0, 1);
    run_seq("mid_c", 32'b1010, 32'b0001, 4);

    // Reset taken while d is high must clear it at that edge.
    apply_reset("s4rst", 1);

    run_seq("long", 32'b01101011101010, 32'b00000100000100, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
